// File: rtl/uart_receiver_if.sv
// ============================================================
// uart_receiver_if : receive-side signal bundle.  Rev 1.0
// ============================================================
`default_nettype none

interface uart_receiver_if;
  logic       enable;
  logic       data_in;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_error;
  logic       busy;

  // master: the receiver itself; slave: the line driver / byte consumer
  modport master (
    input  enable,
    input  data_in,
    output data_out,
    output data_valid,
    output frame_error,
    output busy
  );

  modport slave (
    output enable,
    output data_in,
    input  data_out,
    input  data_valid,
    input  frame_error,
    input  busy
  );
endinterface

`default_nettype wire

// File: rtl/uart_receiver.sv
// ============================================================
// uart_receiver : 8N1 UART receiver, mid-bit sampling.  Rev 1.0
// ============================================================
`default_nettype none

module uart_receiver #(
  parameter int CLOCKS_PER_BIT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_receiver_if.master rx
);

  localparam int               CNT_W     = $clog2(CLOCKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLOCKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           state_q,       state_d;
  logic [CNT_W-1:0] clk_cnt_q,     clk_cnt_d;
  logic [2:0]       bit_cnt_q,     bit_cnt_d;
  logic [7:0]       shift_q,       shift_d;
  logic [7:0]       data_out_q,    data_out_d;
  logic             data_valid_q,  data_valid_d;
  logic             frame_error_q, frame_error_d;
  logic             busy_q,        busy_d;
  logic             sync1_q,       sync1_d;
  logic             sync2_q,       sync2_d;
  logic             prev_q,        prev_d;
  logic             fall_edge;

  assign fall_edge = prev_q & ~sync2_q;

  always_comb begin
    state_d       = state_q;
    clk_cnt_d     = clk_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    frame_error_d = 1'b0;
    sync1_d       = rx.data_in;
    sync2_d       = sync1_q;
    prev_d        = sync2_q;

    case (state_q)
      S_IDLE: begin
        if (rx.enable && fall_edge) begin
          state_d   = S_START;
          clk_cnt_d = '0;
          bit_cnt_d = 3'd0;
        end
      end
      S_START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = '0;
          state_d   = sync2_q ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          shift_d   = {sync2_q, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            state_d = S_STOP;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        // Leave at mid stop bit so an immediately following start edge is seen
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = S_IDLE;
          if (sync2_q) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
          end else begin
            frame_error_d = 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      clk_cnt_q     <= '0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'd0;
      data_out_q    <= 8'd0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      prev_q        <= 1'b1;
    end else begin
      state_q       <= state_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      frame_error_q <= frame_error_d;
      busy_q        <= busy_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      prev_q        <= prev_d;
    end
  end

  assign rx.data_out    = data_out_q;
  assign rx.data_valid  = data_valid_q;
  assign rx.frame_error = frame_error_q;
  assign rx.busy        = busy_q;

endmodule

`default_nettype wire
